alu_flag_unit: RTL and testbench
================================

Name: alu_flag_unit

Overview:
- Execute-stage ALU that computes the datapath result and produces the 5-bit condition flag vector {C,Z,L,F,N}.
- Feeds the processor status register directly downstream. That register loads every clock, so flags_out is a held register and changes only when a flag-setting operation completes.
- Single-cycle ops complete one cycle after start. MUL is an iterative shift-add that takes WIDTH cycles.

Parameters:
- WIDTH, 16, datapath width in bits; must be a power of 2, at least 8.
- SHW, 4, shift-amount width; equals log2(WIDTH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch an operation; accepted only when busy=0.
- op  in  4  opcode, sampled on an accepted start.
- a  in  WIDTH  destination/left operand, sampled on an accepted start.
- b  in  WIDTH  source/right operand, sampled on an accepted start.
- result  out  WIDTH  registered result; holds until the next completion.
- flags_out  out  5  registered {C,Z,L,F,N}: bit4=C, bit3=Z, bit2=L, bit1=F, bit0=N.
- busy  out  1  high while a MUL is iterating.
- done  out  1  one-cycle pulse on the cycle result/flags_out update.

Behaviour:
- Reset (asynchronous, active-high): result=0, flags_out=5'b00000, busy=0, done=0, state=IDLE, multiplier accumulator/counter=0. Reset asserted mid-MUL aborts it with no done pulse.
- States:
  - IDLE: start with op≠MUL -> compute, register result/flags at next edge, done=1 for that one cycle, stay IDLE.
  - IDLE: start with op=MUL -> MUL, busy=1.
  - MUL: one shift-add step per cycle for WIDTH cycles. On the last step: result/flags update, done=1, busy=0, return to IDLE. Total latency WIDTH+1 edges from the start edge.
- start while busy=1 is ignored; operands are not resampled and done is not issued. start with an undefined opcode: done pulses, result and flags unchanged.
- Opcodes (sum = a+b, WIDTH+1 bits; diff = a-b):
  - 0 ADD: result=sum[WIDTH-1:0]. C=sum[WIDTH]. F=signed overflow (a,b same sign, result sign differs). Z=(result==0). N=result[MSB]. L=0.
  - 1 SUB: result=a-b. C=borrow (a<b unsigned). F=signed overflow (a,b differ in sign, result sign differs from a). Z=(a==b). L=(a<b unsigned). N=(a<b signed).
  - 2 CMP: same flags as SUB; result unchanged.
  - 3 AND, 4 OR, 5 XOR: bitwise. Z and N updated from result; C, L, F retain previous values.
  - 6 MOV: result=b; all flags retain.
  - 7 LSH: amount=b[SHW-1:0]. b[SHW]=0 -> left shift; 1 -> logical right. C=last bit shifted out (0 if amount=0). Z and N from result; L and F retain.
  - 8 MUL: unsigned a*b, result=low WIDTH bits. C=(high WIDTH bits ≠ 0). Z and N from the low half. L=0, F=0.
- All arithmetic is modulo 2^WIDTH; wrap-around is reflected only through C/F.
- flags_out and result never change on cycles without done.

Test Plan:
- Reset held, then released -> result=0, flags_out=00000, busy=0, done=0; no done pulse until a start is issued.
- ADD a=16'h7FFF, b=16'h0001 -> next cycle result=16'h8000, flags C=0 Z=0 L=0 F=1 N=1, done high exactly 1 cycle. ADD a=16'hFFFF, b=16'h0001 -> result=0, C=1, Z=1, F=0.
- CMP a=16'h0003, b=16'hFFFE -> result unchanged, Z=0, L=1 (unsigned 3<65534), N=0 (signed 3>-2), C=1. SUB a=b=16'h1234 -> result=0, Z=1, L=0, N=0.
- Flag retention: ADD giving C=1, then AND a=16'h00F0, b=16'h0F00 -> result=0, Z=1, N=0, C still 1. MOV then leaves all flags as-is.
- MUL a=16'h0100, b=16'h0100 -> busy for 16 cycles, done on 17th edge after start, result=0, C=1, Z=1. A start issued mid-MUL is ignored (no extra done, operands not taken).
- Reset asserted at MUL cycle 8 -> busy=0, result=0, flags=0 immediately; no done pulse. A following ADD works normally.

Source files
------------

// File: rtl/alu_flag_unit.sv
// Execute-stage ALU with a registered result and {C,Z,L,F,N} condition flags.
// Single-cycle ops complete on the start edge; MUL runs one shift-add step per cycle.
module alu_flag_unit #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       flags_out,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_CMP = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_MOV = 4'd6;
   localparam logic [3:0] OP_LSH = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef enum logic {IDLE, MUL} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     result_d;
   logic [4:0]           flags_d;
   logic                 done_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, partial;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [SHW-1:0]       count_q, count_d;
   logic [WIDTH:0]       sum, diff, lsh_left, lsh_right;
   logic [SHW-1:0]       lsh_amt;
   logic                 add_ovf, sub_ovf;
   logic                 flag_c, flag_z, flag_l, flag_f, flag_n;

   assign sum       = {1'b0, a} + {1'b0, b};
   assign diff      = {1'b0, a} - {1'b0, b};
   assign add_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

   // The extra guard bit on each side catches the last bit shifted out, and is 0 for a zero shift.
   assign lsh_amt   = b[SHW-1:0];
   assign lsh_left  = {1'b0, a} << lsh_amt;
   assign lsh_right = {a, 1'b0} >> lsh_amt;

   assign partial   = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign busy      = (state_q == MUL);

   always_comb begin
      state_d  = state_q;
      result_d = result;
      done_d   = 1'b0;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      flag_c   = flags_out[4];
      flag_z   = flags_out[3];
      flag_l   = flags_out[2];
      flag_f   = flags_out[1];
      flag_n   = flags_out[0];

      unique case (state_q)
         IDLE: begin
            if (start) begin
               done_d = 1'b1;
               case (op)
                  OP_ADD: begin
                     result_d = sum[WIDTH-1:0];
                     flag_c   = sum[WIDTH];
                     flag_z   = (sum[WIDTH-1:0] == '0);
                     flag_l   = 1'b0;
                     flag_f   = add_ovf;
                     flag_n   = sum[WIDTH-1];
                  end
                  OP_SUB, OP_CMP: begin
                     if (op == OP_SUB) result_d = diff[WIDTH-1:0];
                     flag_c = diff[WIDTH];
                     flag_z = (a == b);
                     flag_l = (a < b);
                     flag_f = sub_ovf;
                     flag_n = ($signed(a) < $signed(b));
                  end
                  OP_AND, OP_OR, OP_XOR: begin
                     if (op == OP_AND)     result_d = a & b;
                     else if (op == OP_OR) result_d = a | b;
                     else                  result_d = a ^ b;
                     flag_z = (result_d == '0);
                     flag_n = result_d[WIDTH-1];
                  end
                  OP_MOV: result_d = b;
                  OP_LSH: begin
                     if (b[SHW]) begin
                        result_d = lsh_right[WIDTH:1];
                        flag_c   = lsh_right[0];
                     end else begin
                        result_d = lsh_left[WIDTH-1:0];
                        flag_c   = lsh_left[WIDTH];
                     end
                     flag_z = (result_d == '0);
                     flag_n = result_d[WIDTH-1];
                  end
                  OP_MUL: begin
                     done_d   = 1'b0;
                     state_d  = MUL;
                     acc_d    = '0;
                     mcand_d  = {{WIDTH{1'b0}}, a};
                     mplier_d = b;
                     count_d  = '0;
                  end
                  default: ;
               endcase
            end
         end
         MUL: begin
            acc_d    = partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
            // The final step publishes the product straight from the adder output.
            if (&count_q) begin
               state_d  = IDLE;
               done_d   = 1'b1;
               result_d = partial[WIDTH-1:0];
               flag_c   = (partial[2*WIDTH-1:WIDTH] != '0);
               flag_z   = (partial[WIDTH-1:0] == '0);
               flag_l   = 1'b0;
               flag_f   = 1'b0;
               flag_n   = partial[WIDTH-1];
            end
         end
         default: state_d = IDLE;
      endcase

      flags_d = {flag_c, flag_z, flag_l, flag_f, flag_n};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         result    <= '0;
         flags_out <= '0;
         done      <= 1'b0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         result    <= result_d;
         flags_out <= flags_d;
         done      <= done_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
      end
   end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Scoreboarded bench for alu_flag_unit: directed corner cases plus randomized ops
// checked against an arithmetic reference model of the flag rules.
module tb_alu_flag_unit;

   localparam int WIDTH = 16;
   localparam int SHW   = 4;
   localparam int SMAX  = (1 << (WIDTH-1)) - 1;
   localparam int SMIN  = -(1 << (WIDTH-1));

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a, b, result;
   logic [4:0]       flags_out;
   logic             busy, done;

   alu_flag_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .result(result), .flags_out(flags_out), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic [4:0]       flg;
      int               due;
      logic [3:0]       opc;
   } exp_t;

   exp_t             sb[$];
   exp_t             mon_e;
   int               checks = 0;
   int               failures = 0;
   int               cyc = 0;
   logic [WIDTH-1:0] model_res = '0;
   logic [4:0]       model_flags = '0;

   always @(posedge clock) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Reference model: flags derived from plain integer arithmetic on the operands.
   task automatic predict(input logic [3:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      int ux, uy, sx, sy, s, amt;
      longint p;
      logic c, z, l, f, n;
      logic [WIDTH-1:0] r;
      ux = x; uy = y; sx = $signed(x); sy = $signed(y);
      {c, z, l, f, n} = model_flags;
      r = model_res;
      case (o)
         4'd0: begin
            s = ux + uy; r = s[WIDTH-1:0];
            c = (s >= (1 << WIDTH)); f = (sx + sy > SMAX) || (sx + sy < SMIN);
            z = (r == 0); n = r[WIDTH-1]; l = 1'b0;
         end
         4'd1, 4'd2: begin
            s = ux - uy;
            if (o == 4'd1) r = s[WIDTH-1:0];
            c = (ux < uy); l = (ux < uy); z = (ux == uy); n = (sx < sy);
            f = (sx - sy > SMAX) || (sx - sy < SMIN);
         end
         4'd3, 4'd4, 4'd5: begin
            r = (o == 4'd3) ? (x & y) : (o == 4'd4) ? (x | y) : (x ^ y);
            z = (r == 0); n = r[WIDTH-1];
         end
         4'd6: r = y;
         4'd7: begin
            amt = uy % WIDTH;
            if ((uy / WIDTH) % 2 == 0) begin
               s = ux << amt; r = s[WIDTH-1:0]; c = (amt != 0) && s[WIDTH];
            end else begin
               r = x >> amt; c = 1'b0;
               if (amt != 0) begin s = ux >> (amt - 1); c = s[0]; end
            end
            z = (r == 0); n = r[WIDTH-1];
         end
         4'd8: begin
            p = longint'(ux) * longint'(uy); r = p[WIDTH-1:0];
            c = ((p >> WIDTH) != 0); z = (r == 0); n = r[WIDTH-1]; l = 1'b0; f = 1'b0;
         end
         default: ;
      endcase
      model_res = r;
      model_flags = {c, z, l, f, n};
   endtask

   // Called at a falling edge with the DUT idle; returns one falling edge later.
   task automatic applyStimulus(input logic [3:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      exp_t e;
      op = o; a = x; b = y; start = 1'b1;
      predict(o, x, y);
      e.res = model_res; e.flg = model_flags; e.opc = o;
      e.due = cyc + 1 + ((o == 4'd8) ? WIDTH : 0);
      sb.push_back(e);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (sb.size() != 0 && n < WIDTH + 6) begin
         @(negedge clock);
         n++;
      end
      if (sb.size() != 0) begin
         checks++; failures++;
         $display("[TB] FAIL done_timeout: %0d completions outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   function automatic logic [WIDTH-1:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b0, {(WIDTH-1){1'b1}}};
         3:       return {1'b1, {(WIDTH-1){1'b0}}};
         default: return WIDTH'($urandom);
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding prediction.
   always @(negedge clock) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, expected 0", cyc);
         end else begin
            mon_e = sb.pop_front();
            checkOutput($sformatf("op%0d_result", mon_e.opc), result, mon_e.res);
            checkOutput($sformatf("op%0d_flags", mon_e.opc), flags_out, mon_e.flg);
            checkOutput($sformatf("op%0d_done_cycle", mon_e.opc), cyc, mon_e.due);
         end
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clock);
      checkOutput("reset_result", result, 0);
      checkOutput("reset_flags", flags_out, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      checkOutput("idle_done", done, 0);

      applyStimulus(4'd0, 16'h7FFF, 16'h0001); waitIdle();
      checkOutput("add_ovf_result", result, 16'h8000);
      checkOutput("add_ovf_flags", flags_out, 5'b00011);
      applyStimulus(4'd0, 16'hFFFF, 16'h0001); waitIdle();
      checkOutput("add_carry_flags", flags_out, 5'b11000);
      applyStimulus(4'd3, 16'h00F0, 16'h0F00); waitIdle();
      checkOutput("and_keep_c_flags", flags_out, 5'b11000);
      applyStimulus(4'd6, 16'h0000, 16'h1234); waitIdle();
      checkOutput("mov_result", result, 16'h1234);
      checkOutput("mov_flags", flags_out, 5'b11000);
      applyStimulus(4'd2, 16'h0003, 16'hFFFE); waitIdle();
      checkOutput("cmp_result", result, 16'h1234);
      checkOutput("cmp_flags", flags_out, 5'b10100);
      applyStimulus(4'd1, 16'h1234, 16'h1234); waitIdle();
      checkOutput("sub_eq_flags", flags_out, 5'b01000);

      // MUL: busy for WIDTH cycles, with a start in the middle that must be ignored.
      applyStimulus(4'd8, 16'h0100, 16'h0100);
      for (int i = 0; i < WIDTH; i++) begin
         if (i == 0 || i == 7 || i == WIDTH - 1) checkOutput($sformatf("mul_busy_%0d", i), busy, 1);
         if (i == 5) begin op = 4'd0; a = 16'h0001; b = 16'h0001; start = 1'b1; end
         if (i == 6) start = 1'b0;
         @(negedge clock);
      end
      waitIdle();
      checkOutput("mul_busy_end", busy, 0);
      checkOutput("mul_result", result, 16'h0000);
      checkOutput("mul_flags", flags_out, 5'b11000);

      // Reset in the middle of a multiply aborts it without a done pulse.
      applyStimulus(4'd8, 16'h1234, 16'h5678);
      repeat (7) @(negedge clock);
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_result", result, 0);
      checkOutput("abort_flags", flags_out, 0);
      checkOutput("abort_done", done, 0);
      sb.delete();
      model_res = '0; model_flags = '0;
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      applyStimulus(4'd0, 16'h0005, 16'h0003); waitIdle();
      checkOutput("post_abort_result", result, 16'h0008);
      checkOutput("post_abort_flags", flags_out, 5'b00000);

      for (int i = 0; i < 200; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand());
         if ($urandom_range(0, 3) == 0) waitIdle();
         else if (busy) waitIdle();
      end
      waitIdle();
      repeat (3) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
